// File: rtl/spike_tx_scheduler.sv
// spike_tx_scheduler
//   Collects one-cycle spike pulses from a neuron array and holds each one in a
//   pending flag. A round-robin arbiter grants one pending neuron at a time.
//   The granted neuron becomes an event word {timestamp, neuron_id}. The block
//   then steps a width-reducing serializer through its chunks against a
//   byte-wide transmitter handshake.
//
// Handshake summary:
//   ser_wr loads the event word into the serializer. Each chunk waits in START
//   for tx_ready, then pulses tx_start, provided ser_val says the serializer
//   output is valid. The block then waits for tx_done and pulses ser_next to
//   advance to the next chunk. A tx_ready with ser_val low is a protocol
//   error: err is set and the transfer is abandoned.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ts_en            timestamp counter increment enable
//   spike_in         one-cycle spike pulses, bit i = neuron i
//   ser_wr/ser_next  serializer load / shift strobes
//   ser_data         event word {ts, id} presented to the serializer
//   ser_val          serializer output-valid flag
//   tx_ready/tx_start/tx_done  transmitter handshake
//   busy             FSM not in IDLE
//   drop_cnt         saturating count of spikes lost to a full pending flag
//   err              sticky protocol error
module spike_tx_scheduler #(
    parameter int N_NEUR = 16,
    parameter int ID_W   = 4,
    parameter int TS_W   = 20,
    parameter int OUT_W  = 8,
    parameter int IN_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ts_en,
    input  logic [N_NEUR-1:0] spike_in,
    output logic              ser_wr,
    output logic              ser_next,
    output logic [IN_W-1:0]   ser_data,
    input  logic              ser_val,
    input  logic              tx_ready,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic              err
);

    localparam int N_CHUNK = IN_W / OUT_W;
    localparam int CNT_W   = $clog2(N_CHUNK + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t              state_q, state_d;
    logic [N_NEUR-1:0]   pend_q, pend_d;
    logic [TS_W-1:0]     ts_q;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [IN_W-1:0]     ser_data_q, ser_data_d;
    logic [CNT_W-1:0]    chunk_q, chunk_d;
    logic [7:0]          drop_q, drop_d;
    logic                err_q, err_d;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_id;
    logic                grant;
    logic [N_NEUR-1:0]   gnt_mask;

    // Round-robin search starting just after the last granted neuron.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= N_NEUR; k++) begin
            if (!gnt_found && pend_q[(int'(rr_q) + k) % N_NEUR]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(rr_q) + k) % N_NEUR);
            end
        end
    end

    assign grant = (state_q == IDLE) && gnt_found;

    always_comb begin
        gnt_mask = '0;
        for (int i = 0; i < N_NEUR; i++) begin
            gnt_mask[i] = grant && (gnt_id == ID_W'(i));
        end
    end

    // Pending flags and drop counting. A spike on a neuron that is granted in
    // the same cycle is not a drop: the grant frees the flag and the new spike
    // takes it over.
    always_comb begin
        pend_d = (pend_q & ~gnt_mask) | spike_in;
        drop_d = drop_q;
        for (int i = 0; i < N_NEUR; i++) begin
            if (spike_in[i] && pend_q[i] && !gnt_mask[i] && drop_d != 8'hFF) begin
                drop_d = drop_d + 8'd1;
            end
        end
    end

    // Transfer FSM
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        ser_data_d = ser_data_q;
        chunk_d    = chunk_q;
        err_d      = err_q;
        ser_wr     = 1'b0;
        ser_next   = 1'b0;
        tx_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    rr_d       = gnt_id;
                    ser_data_d = {ts_q, gnt_id};
                    chunk_d    = CNT_W'(N_CHUNK);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                ser_wr  = 1'b1;
                state_d = START;
            end
            START: begin
                if (tx_ready) begin
                    if (ser_val) begin
                        tx_start = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (tx_done) begin
                    ser_next = 1'b1;
                    chunk_d  = chunk_q - CNT_W'(1);
                    state_d  = (chunk_q == CNT_W'(1)) ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            ts_q       <= '0;
            rr_q       <= ID_W'(N_NEUR - 1);
            ser_data_q <= '0;
            chunk_q    <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ts_q       <= ts_en ? ts_q + TS_W'(1) : ts_q;
            rr_q       <= rr_d;
            ser_data_q <= ser_data_d;
            chunk_q    <= chunk_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign ser_data = ser_data_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;
    assign err      = err_q;

endmodule
